inv_quarter_cha: RTL and testbench
==================================

Name: inv_quarter_cha

Overview:
- Iterative inverse ChaCha quarter-round engine. Undoes the forward quarter round (add/xor/rotate by 16, 12, 8, 7).
- Used on the decode/verification side of the ChaCha datapath, for example to unwind a state to check a round schedule.
- Takes one (a,b,c,d) word set over a valid/ready handshake and applies ITER inverse quarter rounds, one half-step per clock.
- Returns the result over a valid/ready handshake.

Parameters:
- ITER, 1, number of inverse quarter rounds applied per transaction. Legal range is 1..255; 0 is illegal.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word set is valid.
- in_ready  output  1  engine can accept an input.
- a_in, b_in, c_in, d_in  input  32 each  forward quarter-round output words.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- a_out, b_out, c_out, d_out  output  32 each  recovered words, driven from registers.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous, active-high. In any cycle where rst is sampled high:
  - state goes to IDLE;
  - step and iteration counters clear;
  - a/b/c/d registers clear to 0;
  - out_valid = 0; busy = 0.
- in_ready is 0 while rst is high. In the first cycle after rst deasserts, in_ready = 1.
- States:
  - IDLE: in_ready = 1. When in_valid && in_ready, load a_in..d_in into the registers, set step = 0 and iter = 0, go to RUN.
  - RUN: apply one half-step per cycle to the registers. step increments modulo 4. When step wraps 3 -> 0, iter increments. After step 3 with iter == ITER-1, go to DONE.
  - DONE: out_valid = 1 and outputs are held stable. When out_ready is high, go to IDLE.
- Half-steps. rorN is a 32-bit rotate right; all add/subtract is modulo 2^32. Every right-hand side uses the current register values, so each assignment pair updates in parallel.
  - step 0: b <= ror7(b) ^ c; c <= c - d
  - step 1: d <= ror8(d) ^ a; a <= a - b
  - step 2: b <= ror12(b) ^ c; c <= c - d
  - step 3: d <= ror16(d) ^ a; a <= a - b
- Latency: for an accept at edge E, out_valid is first high after edge E + 4*ITER.
- Throughput: one transaction per 4*ITER + 2 cycles when out_ready is held high. There is no accept in the cycle DONE->IDLE.
- in_ready is 0 in RUN and DONE. Input changes outside IDLE are ignored.
- Backpressure: DONE may last indefinitely. a_out..d_out and out_valid must not change until the out_ready handshake completes.
- Reset mid-RUN or mid-DONE: the transaction is dropped with no output, and the engine returns to the reset state.
- When in_valid is high in the same cycle as the DONE handshake, the input is not accepted. It is accepted in the following IDLE cycle.
- A forward quarter round applied ITER times, followed by this block with the same ITER, must return the original words exactly.

Test Plan:
- RFC 7539 §2.1.1 vector, ITER=1. Input a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb -> out a=11111111, b=01020304, c=9b8d6f43, d=01234567. out_valid rises exactly 4 cycles after the accept edge.
- All-zero input, ITER=1 and ITER=3 -> all outputs 0. Latency is 4 and 12 cycles respectively.
- Round trip, ITER=4. 1000 random (a,b,c,d) sets, each passed through a software forward quarter round 4 times and fed to the block -> outputs equal the originals. in_ready is low for all RUN/DONE cycles.
- Backpressure, ITER=1 RFC vector. out_ready held low for 20 cycles -> out_valid and outputs stay stable. in_valid pulsed during DONE is ignored. The handshake completes, in_ready returns the next cycle, and the new input is accepted.
- Reset mid-operation. Assert rst for 1 cycle at step 2 of RUN -> next cycle: state IDLE, out_valid=0, outputs 0, in_ready=1. The following transaction produces the correct result.
- Back-to-back. in_valid and out_ready held high, ITER=1 -> accepts spaced exactly 6 cycles apart. Each result matches its input's expected value.

Source files
------------

// File: rtl/inv_quarter_cha.sv
// Iterative inverse ChaCha quarter-round engine.
// Accepts one (a,b,c,d) word set, unwinds ITER forward quarter rounds by
// applying one inverse half-step per clock, then presents the recovered
// words until the consumer takes them.
module inv_quarter_cha #(
  parameter int unsigned ITER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration index of the final inverse round; ITER is limited to 1..255
  // so the counter fits in eight bits.
  localparam logic [7:0] LAST_ITER = 8'(ITER - 1);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  iter_q, iter_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] c_q, c_d;
  logic [31:0] d_q, d_d;
  logic        accept;

  // Fixed-distance rotate-right helpers, one per forward rotation amount.
  function automatic logic [31:0] ror7(input logic [31:0] x);
    return {x[6:0], x[31:7]};
  endfunction

  function automatic logic [31:0] ror8(input logic [31:0] x);
    return {x[7:0], x[31:8]};
  endfunction

  function automatic logic [31:0] ror12(input logic [31:0] x);
    return {x[11:0], x[31:12]};
  endfunction

  function automatic logic [31:0] ror16(input logic [31:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  // The engine only advertises readiness in IDLE, and never while reset is
  // being applied, so a word set offered during reset is not taken.
  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Next-state and datapath: load in IDLE, unwind one half-step per cycle in
  // RUN (the forward round undone last step first), hold everything in DONE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    iter_d  = iter_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = c_in;
          d_d     = d_in;
          step_d  = 2'd0;
          iter_d  = 8'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        case (step_q)
          2'd0: begin
            b_d = ror7(b_q) ^ c_q;
            c_d = c_q - d_q;
          end
          2'd1: begin
            d_d = ror8(d_q) ^ a_q;
            a_d = a_q - b_q;
          end
          2'd2: begin
            b_d = ror12(b_q) ^ c_q;
            c_d = c_q - d_q;
          end
          default: begin
            d_d = ror16(d_q) ^ a_q;
            a_d = a_q - b_q;
          end
        endcase

        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          if (iter_q == LAST_ITER) begin
            iter_d  = 8'd0;
            state_d = DONE;
          end else begin
            iter_d = iter_q + 8'd1;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and word registers; reset drops any transaction in
  // flight and clears the words so no stale result is visible afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      iter_q  <= 8'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      d_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      iter_q  <= iter_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign c_out     = c_q;
  assign d_out     = d_q;

endmodule

// File: tb/tb_inv_quarter_cha.sv
// Self-checking bench for inv_quarter_cha: three engines (ITER = 1, 3, 4)
// share clock and reset; a transaction-level model predicts every output.
module tb_inv_quarter_cha;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } quad_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        inValid [3];
  logic        inReady [3];
  logic        outValid[3];
  logic        outReady[3];
  logic        busy    [3];
  logic [31:0] aIn [3], bIn [3], cIn [3], dIn [3];
  logic [31:0] aOut[3], bOut[3], cOut[3], dOut[3];

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  // Model state per engine.
  bit    pending[3];
  bit    zeroed [3];
  int    accCyc [3];
  quad_t expQ   [3];
  bit    started = 1'b0;

  // Free-running clock.
  always #5 clock = ~clock;

  inv_quarter_cha #(.ITER(1)) dut1 (
    .clk(clock), .rst(reset),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a_in(aIn[0]), .b_in(bIn[0]), .c_in(cIn[0]), .d_in(dIn[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .a_out(aOut[0]), .b_out(bOut[0]), .c_out(cOut[0]), .d_out(dOut[0]),
    .busy(busy[0])
  );

  inv_quarter_cha #(.ITER(3)) dut3 (
    .clk(clock), .rst(reset),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a_in(aIn[1]), .b_in(bIn[1]), .c_in(cIn[1]), .d_in(dIn[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .a_out(aOut[1]), .b_out(bOut[1]), .c_out(cOut[1]), .d_out(dOut[1]),
    .busy(busy[1])
  );

  inv_quarter_cha #(.ITER(4)) dut4 (
    .clk(clock), .rst(reset),
    .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a_in(aIn[2]), .b_in(bIn[2]), .c_in(cIn[2]), .d_in(dIn[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .a_out(aOut[2]), .b_out(bOut[2]), .c_out(cOut[2]), .d_out(dOut[2]),
    .busy(busy[2])
  );

  function automatic int iterOf(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Forward ChaCha quarter round as written in RFC 7539.
  function automatic quad_t fwdQr(input quad_t q);
    quad_t r = q;
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 16);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 12);
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 8);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 7);
    return r;
  endfunction

  // Forward round undone operation by operation, last one first.
  function automatic quad_t invQr(input quad_t q);
    quad_t r = q;
    r.b = rotl(r.b, 25) ^ r.c; r.c = r.c - r.d;
    r.d = rotl(r.d, 24) ^ r.a; r.a = r.a - r.b;
    r.b = rotl(r.b, 20) ^ r.c; r.c = r.c - r.d;
    r.d = rotl(r.d, 16) ^ r.a; r.a = r.a - r.b;
    return r;
  endfunction

  function automatic quad_t invN(input quad_t q, input int n);
    quad_t r = q;
    for (int k = 0; k < n; k++) r = invQr(r);
    return r;
  endfunction

  // Single comparison primitive: counts every check, reports mismatches.
  task automatic checkOutput(input string name, input int i,
                             input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d] got %h expected %h at cycle %0d",
               name, i, act, exp, cyc);
    end
  endtask

  // Transaction model: tracks accepts, handshakes and resets at each edge.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        pending[i] = 1'b0;
        zeroed[i]  = 1'b1;
      end else if (!pending[i] && inValid[i]) begin
        pending[i] = 1'b1;
        zeroed[i]  = 1'b0;
        accCyc[i]  = cyc + 1;
        expQ[i]    = invN('{a: aIn[i], b: bIn[i], c: cIn[i], d: dIn[i]}, iterOf(i));
      end else if (pending[i] && (cyc - accCyc[i] >= 4 * iterOf(i)) && outReady[i]) begin
        pending[i] = 1'b0;
      end
    end
    if (reset) started = 1'b1;
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every engine against the model.
  always @(negedge clock) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        logic expOv;
        expOv = pending[i] && (cyc - accCyc[i] >= 4 * iterOf(i));
        checkOutput("inReady", i, 32'(inReady[i]), 32'(!reset && !pending[i]));
        checkOutput("outValid", i, 32'(outValid[i]), 32'(expOv));
        checkOutput("busy", i, 32'(busy[i]), 32'(pending[i]));
        if (expOv) begin
          checkOutput("aOut", i, aOut[i], expQ[i].a);
          checkOutput("bOut", i, bOut[i], expQ[i].b);
          checkOutput("cOut", i, cOut[i], expQ[i].c);
          checkOutput("dOut", i, dOut[i], expQ[i].d);
        end
        if (zeroed[i]) begin
          checkOutput("zeroWords", i, aOut[i] | bOut[i] | cOut[i] | dOut[i], 32'd0);
        end
      end
    end
  end

  task automatic timeoutFail(input string name, input int i);
    asserts++;
    fails++;
    $display("[TB] FAIL %s[%0d] timed out at cycle %0d", name, i, cyc);
  endtask

  // Offer a word set and return the cycle number of the accepting edge.
  task automatic applyStimulus(input int i, input quad_t q, output int acc);
    int n = 0;
    @(negedge clock);
    aIn[i] = q.a; bIn[i] = q.b; cIn[i] = q.c; dIn[i] = q.d;
    inValid[i] = 1'b1;
    while (!inReady[i] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) timeoutFail("acceptWait", i);
    @(posedge clock);
    #1;
    acc = cyc;
    inValid[i] = 1'b0;
  endtask

  // Wait for the result, pin latency and words to literal expectations,
  // then complete the handshake.
  task automatic collectResult(input int i, input int acc, input int expLat,
                               input quad_t q, input string name);
    int n = 0;
    @(negedge clock);
    while (!outValid[i] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      timeoutFail({name, "Wait"}, i);
    end else begin
      checkOutput({name, "Latency"}, i, 32'(cyc - acc), 32'(expLat));
      checkOutput({name, "A"}, i, aOut[i], q.a);
      checkOutput({name, "B"}, i, bOut[i], q.b);
      checkOutput({name, "C"}, i, cOut[i], q.c);
      checkOutput({name, "D"}, i, dOut[i], q.d);
    end
    outReady[i] = 1'b1;
    @(posedge clock);
    #1;
    outReady[i] = 1'b0;
  endtask

  quad_t rfcIn   = '{a: 32'hea2a92f4, b: 32'hcb1cf8ce, c: 32'h4581472e, d: 32'h5881c4bb};
  quad_t rfcOrig = '{a: 32'h11111111, b: 32'h01020304, c: 32'h9b8d6f43, d: 32'h01234567};
  quad_t zeroQ   = '0;

  // Directed sequence.
  initial begin
    int    acc;
    int    accs[4];
    quad_t orig, x;
    quad_t vecs[4];

    for (int i = 0; i < 3; i++) begin
      inValid[i] = 1'b0; outReady[i] = 1'b0;
      aIn[i] = '0; bIn[i] = '0; cIn[i] = '0; dIn[i] = '0;
    end

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("resetInReady", 0, 32'(inReady[0]), 32'd1);
    checkOutput("resetOutValid", 0, 32'(outValid[0]), 32'd0);
    checkOutput("resetBusy", 0, 32'(busy[0]), 32'd0);
    checkOutput("resetA", 0, aOut[0], 32'd0);

    // Pin the model to the published vector.
    x = fwdQr(rfcOrig);
    checkOutput("modelFwd", 0, x.a ^ x.b ^ x.c ^ x.d, rfcIn.a ^ rfcIn.b ^ rfcIn.c ^ rfcIn.d);
    checkOutput("modelFwdA", 0, x.a, rfcIn.a);
    x = invQr(rfcIn);
    checkOutput("modelInvA", 0, x.a, rfcOrig.a);
    checkOutput("modelInvD", 0, x.d, rfcOrig.d);

    $display("[TB] RFC vector, ITER=1");
    applyStimulus(0, rfcIn, acc);
    collectResult(0, acc, 4, rfcOrig, "rfc");

    $display("[TB] all-zero input, ITER=1 and ITER=3");
    applyStimulus(0, zeroQ, acc);
    collectResult(0, acc, 4, zeroQ, "zero1");
    applyStimulus(1, zeroQ, acc);
    collectResult(1, acc, 12, zeroQ, "zero3");

    $display("[TB] round trip, ITER=4");
    for (int k = 0; k < 1000; k++) begin
      orig = '{a: $urandom, b: $urandom, c: $urandom, d: $urandom};
      x = orig;
      for (int r = 0; r < 4; r++) x = fwdQr(x);
      applyStimulus(2, x, acc);
      collectResult(2, acc, 16, orig, "roundTrip");
    end

    $display("[TB] backpressure");
    applyStimulus(0, rfcIn, acc);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (n == 8) begin
        aIn[0] = 32'h0; bIn[0] = 32'h0; cIn[0] = 32'h0; dIn[0] = 32'h0;
        inValid[0] = 1'b1;
      end
    end
    checkOutput("holdValid", 0, 32'(outValid[0]), 32'd1);
    checkOutput("holdA", 0, aOut[0], rfcOrig.a);
    checkOutput("holdC", 0, cOut[0], rfcOrig.c);
    outReady[0] = 1'b1;
    @(posedge clock);
    #1 outReady[0] = 1'b0;
    @(negedge clock);
    checkOutput("readyAfterDone", 0, 32'(inReady[0]), 32'd1);
    @(posedge clock);
    #1;
    acc = cyc;
    inValid[0] = 1'b0;
    collectResult(0, acc, 4, zeroQ, "afterHold");

    $display("[TB] reset during RUN");
    applyStimulus(0, rfcIn, acc);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("midRstOutValid", 0, 32'(outValid[0]), 32'd0);
    checkOutput("midRstInReady", 0, 32'(inReady[0]), 32'd1);
    checkOutput("midRstBusy", 0, 32'(busy[0]), 32'd0);
    checkOutput("midRstWords", 0, aOut[0] | bOut[0] | cOut[0] | dOut[0], 32'd0);
    applyStimulus(0, rfcIn, acc);
    collectResult(0, acc, 4, rfcOrig, "postRst");

    $display("[TB] back-to-back, ITER=1");
    vecs[0] = rfcIn;
    vecs[1] = zeroQ;
    vecs[2] = '{a: 32'hdeadbeef, b: 32'h01234567, c: 32'h89abcdef, d: 32'hfeedface};
    vecs[3] = fwdQr(vecs[2]);
    outReady[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      int n = 0;
      @(negedge clock);
      aIn[0] = vecs[j].a; bIn[0] = vecs[j].b; cIn[0] = vecs[j].c; dIn[0] = vecs[j].d;
      inValid[0] = 1'b1;
      while (!inReady[0] && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) timeoutFail("b2bAccept", 0);
      @(posedge clock);
      #1 accs[j] = cyc;
    end
    inValid[0] = 1'b0;
    repeat (10) @(posedge clock);
    #1 outReady[0] = 1'b0;
    for (int j = 1; j < 4; j++) begin
      checkOutput("b2bSpacing", j, 32'(accs[j] - accs[j - 1]), 32'd6);
    end

    repeat (4) @(posedge clock);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
